// File: rtl/lcd_timing_generator_if.sv
// rtl/lcd_timing_generator_if.sv - raster timing bus between the LCD timing generator and its consumers
//
// Purpose: carries the pixel-rate enable into the generator and the registered
//          sync/data-enable/coordinate/strobe outputs back out.
// Signals:
//   en           pixel-rate enable (driven by the consumer side)
//   hsync, vsync sync outputs, asserted level chosen by the generator's SYNC_POL
//   de           data enable, high inside the visible window
//   x, y         registered pixel position
//   line_start   pulse when x==0
//   frame_start  pulse when x==0 and y==0
// Modports: master = timing generator, slave = pattern logic / pins / testbench.

interface lcd_timing_generator_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic           en;
  logic           hsync;
  logic           vsync;
  logic           de;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           line_start;
  logic           frame_start;

  modport master (
    input  en,
    output hsync, vsync, de, x, y, line_start, frame_start
  );

  modport slave (
    output en,
    input  hsync, vsync, de, x, y, line_start, frame_start
  );
endinterface

// File: rtl/lcd_timing_generator.sv
// rtl/lcd_timing_generator.sv - raster timing generator for the 480x272 parallel RGB LCD
//
// Purpose: counts pixels (hc) and lines (vc) at the pixel-clock enable rate and
//          registers hsync, vsync, de, x, y, line_start and frame_start for the
//          position the counters held before each enabled edge.
// Ports:
//   clk  in   pixel clock from the board PLL
//   rst  in   synchronous reset, active-high, has priority over en
//   bus  master modport of lcd_timing_generator_if (en in, timing outputs out)

module lcd_timing_generator #(
  parameter int H_DISPLAY = 480,
  parameter int H_FRONT   = 2,
  parameter int H_SYNC    = 41,
  parameter int H_BACK    = 2,
  parameter int V_DISPLAY = 272,
  parameter int V_FRONT   = 2,
  parameter int V_SYNC    = 10,
  parameter int V_BACK    = 2,
  parameter bit SYNC_POL  = 1'b0,
  parameter int X_W       = 10,
  parameter int Y_W       = 9
) (
  input logic                    clk,
  input logic                    rst,
  lcd_timing_generator_if.master bus
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Boundaries held at 32 bits and compared against zero-extended counters, so a
  // boundary equal to 2**X_W (or 2**Y_W) never wraps to zero.
  localparam logic [31:0] H_VIS_END  = 32'(H_DISPLAY);
  localparam logic [31:0] H_SYNC_BEG = 32'(H_DISPLAY + H_FRONT);
  localparam logic [31:0] H_SYNC_END = 32'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [31:0] H_LAST     = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_VIS_END  = 32'(V_DISPLAY);
  localparam logic [31:0] V_SYNC_BEG = 32'(V_DISPLAY + V_FRONT);
  localparam logic [31:0] V_SYNC_END = 32'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [31:0] V_LAST     = 32'(V_TOTAL - 1);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  logic [X_W-1:0] hc;
  logic [Y_W-1:0] vc;
  logic [31:0]    hc_w;
  logic [31:0]    vc_w;
  logic           h_vis;
  logic           v_vis;
  logic           h_sync_act;
  logic           v_sync_act;
  logic           h_end;
  logic           v_end;

  always_comb begin
    hc_w       = 32'(hc);
    vc_w       = 32'(vc);
    h_vis      = hc_w < H_VIS_END;
    v_vis      = vc_w < V_VIS_END;
    h_sync_act = (hc_w >= H_SYNC_BEG) && (hc_w < H_SYNC_END);
    // vsync decodes on the line number only, so it spans whole lines.
    v_sync_act = (vc_w >= V_SYNC_BEG) && (vc_w < V_SYNC_END);
    h_end      = hc_w == H_LAST;
    v_end      = vc_w == V_LAST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc              <= '0;
      vc              <= '0;
      bus.x           <= '0;
      bus.y           <= '0;
      bus.de          <= 1'b0;
      bus.hsync       <= SYNC_OFF;
      bus.vsync       <= SYNC_OFF;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else if (bus.en) begin
      // Outputs describe the pre-edge position; strobes are only rewritten on
      // enabled edges, so a held cycle keeps whatever the last one produced.
      bus.x           <= hc;
      bus.y           <= vc;
      bus.de          <= h_vis && v_vis;
      bus.hsync       <= h_sync_act ? SYNC_ON : SYNC_OFF;
      bus.vsync       <= v_sync_act ? SYNC_ON : SYNC_OFF;
      bus.line_start  <= hc == '0;
      bus.frame_start <= (hc == '0) && (vc == '0);

      if (h_end) begin
        hc <= '0;
        vc <= v_end ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

endmodule
